// File: rtl/burst_carrier_gen.sv
// Ultrasonic carrier burst generator for the phased-array delay line.
// Freezes the beam-angle select and inserts drain windows so a burst never straddles two angles.
module burst_carrier_gen #(
   parameter int HALF_PERIOD = 625,
   parameter int FLUSH_CLKS  = 8501
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       continuous,
   input  logic [7:0] burst_len,
   input  logic [3:0] select_in,
   output logic [3:0] select_out,
   output logic       pwm_out,
   output logic       busy,
   output logic       done
);

   localparam int HP_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int FL_W = (FLUSH_CLKS > 1) ? $clog2(FLUSH_CLKS) : 1;
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CLKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      BURST = 2'd2,
      TAIL  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [HP_W-1:0] half_cnt_q, half_cnt_d;
   logic            low_phase_q, low_phase_d;
   logic [7:0]      per_cnt_q, per_cnt_d;
   logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [7:0]      len_q, len_d;
   logic [3:0]      select_q, select_d;
   logic            pwm_q, pwm_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic flush_last;
   logic half_last;
   logic len_ok;
   logic launch;

   assign flush_last = (flush_cnt_q == FL_LAST);
   assign half_last  = (half_cnt_q == HP_LAST);
   assign len_ok     = (burst_len != 8'd0);

   // Sample points: a fresh start from IDLE, or the last TAIL cycle with auto-repeat.
   assign launch = len_ok &&
                   (((state_q == IDLE) && start) ||
                    ((state_q == TAIL) && flush_last && continuous));

   always_comb begin
      state_d     = state_q;
      half_cnt_d  = half_cnt_q;
      low_phase_d = low_phase_q;
      per_cnt_d   = per_cnt_q;
      flush_cnt_d = flush_cnt_q;
      len_d       = len_q;
      select_d    = select_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
         end
         FLUSH: begin
            if (flush_last) begin
               state_d     = BURST;
               flush_cnt_d = '0;
               half_cnt_d  = '0;
               low_phase_d = 1'b0;
               per_cnt_d   = 8'd0;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         BURST: begin
            if (half_last) begin
               half_cnt_d  = '0;
               low_phase_d = ~low_phase_q;
               if (low_phase_q) begin
                  if (per_cnt_q == (len_q - 8'd1)) begin
                     state_d     = TAIL;
                     flush_cnt_d = '0;
                     per_cnt_d   = 8'd0;
                  end else begin
                     per_cnt_d = per_cnt_q + 8'd1;
                  end
               end
            end else begin
               half_cnt_d = half_cnt_q + 1'b1;
            end
         end
         TAIL: begin
            if (flush_last) begin
               done_d      = 1'b1;
               flush_cnt_d = '0;
               state_d     = IDLE;
               busy_d      = 1'b0;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // The flush decision compares against the angle the delay line currently holds.
      if (launch) begin
         len_d       = burst_len;
         select_d    = select_in;
         busy_d      = 1'b1;
         flush_cnt_d = '0;
         half_cnt_d  = '0;
         low_phase_d = 1'b0;
         per_cnt_d   = 8'd0;
         state_d     = (select_in != select_q) ? FLUSH : BURST;
      end

      if (abort) begin
         state_d     = IDLE;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         flush_cnt_d = '0;
         half_cnt_d  = '0;
         low_phase_d = 1'b0;
         per_cnt_d   = 8'd0;
         select_d    = select_q;
         len_d       = len_q;
      end

      // Output follows the next state so it lines up with the first cycle of each phase.
      pwm_d = (state_d == BURST) && !low_phase_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         half_cnt_q  <= '0;
         low_phase_q <= 1'b0;
         per_cnt_q   <= 8'd0;
         flush_cnt_q <= '0;
         len_q       <= 8'd0;
         select_q    <= 4'd0;
         pwm_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         half_cnt_q  <= half_cnt_d;
         low_phase_q <= low_phase_d;
         per_cnt_q   <= per_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         len_q       <= len_d;
         select_q    <= select_d;
         pwm_q       <= pwm_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign select_out = select_q;
   assign pwm_out    = pwm_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_burst_carrier_gen.sv
// Directed bench for burst_carrier_gen with a shortened carrier and flush window.
module tb_burst_carrier_gen;

   localparam int HP = 4;
   localparam int FL = 10;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       continuous;
   logic [7:0] burst_len;
   logic [3:0] select_in;
   logic [3:0] select_out;
   logic       pwm_out;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   burst_carrier_gen #(
      .HALF_PERIOD(HP),
      .FLUSH_CLKS (FL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .continuous(continuous),
      .burst_len (burst_len),
      .select_in (select_in),
      .select_out(select_out),
      .pwm_out   (pwm_out),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [3:0] exp_sel);
      chk({tag, "_pwm"}, {7'd0, pwm_out}, 8'd0);
      chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
      chk({tag, "_done"}, {7'd0, done}, 8'd0);
      chk({tag, "_sel"}, {4'd0, select_out}, {4'd0, exp_sel});
   endtask

   // Called in the first cycle after a launch edge; returns in the done cycle.
   task automatic check_seq(input int len, input bit flush, input bit relaunch_in,
                            input bit relaunch_out, input bit flush_next,
                            input logic [3:0] exp_sel, input int poke_k);
      int nf;
      int nb;
      int total;
      logic ep;
      nf    = flush ? FL : 0;
      nb    = 2 * HP * len;
      total = nf + nb + FL;
      for (int k = 0; k < total; k++) begin
         ep = ((k >= nf) && (k < nf + nb)) ? (((k - nf) % (2 * HP)) < HP) : 1'b0;
         chk("seq_pwm", {7'd0, pwm_out}, {7'd0, ep});
         chk("seq_busy", {7'd0, busy}, 8'd1);
         chk("seq_done", {7'd0, done}, {7'd0, (k == 0) && relaunch_in});
         chk("seq_sel", {4'd0, select_out}, {4'd0, exp_sel});
         if (k == poke_k) begin
            start     = 1'b1;
            select_in = 4'd9;
         end
         if (k == poke_k + 1) start = 1'b0;
         tick();
      end
      chk("end_done", {7'd0, done}, 8'd1);
      chk("end_busy", {7'd0, busy}, {7'd0, relaunch_out});
      chk("end_pwm", {7'd0, pwm_out}, {7'd0, relaunch_out && !flush_next});
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      continuous = 1'b0;
      burst_len  = 8'd0;
      select_in  = 4'd0;
      #1;
      chk_idle("reset", 4'd0);
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk_idle("post_reset", 4'd0);

      // 1: same angle, no flush
      burst_len = 8'd3;
      select_in = 4'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check_seq(3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, -1);
      tick();
      chk_idle("s1_after", 4'd0);
      $display("scenario 1: len=3 sel=0 no flush, checks=%0d", checks);

      // 2: new angle forces flush; start and select change while busy are ignored
      select_in = 4'd5;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check_seq(3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle("s2_after", 4'd5);
      end
      select_in = 4'd5;
      $display("scenario 2: len=3 sel=5 with flush, checks=%0d", checks);

      // 3: zero length is not a trigger
      burst_len = 8'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         chk_idle("s3_len0", 4'd5);
         tick();
      end
      $display("scenario 3: burst_len=0 ignored, checks=%0d", checks);

      // 4: continuous repeat, then drop continuous
      burst_len  = 8'd2;
      continuous = 1'b1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check_seq(2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, -1);
      check_seq(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, -1);
      continuous = 1'b0;
      check_seq(2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, -1);
      tick();
      chk_idle("s4_after", 4'd5);
      $display("scenario 4: continuous len=2, checks=%0d", checks);

      // 5: abort in the second carrier period, with a stray start while busy
      burst_len = 8'd3;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         chk("s5_pwm", {7'd0, pwm_out}, {7'd0, ((k - 1) % 8) < 4});
         chk("s5_busy", {7'd0, busy}, 8'd1);
         if (k == 3) start = 1'b1;
         if (k == 4) start = 1'b0;
         tick();
      end
      chk("s5_pwm_p2", {7'd0, pwm_out}, 8'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 40; i++) begin
         chk_idle("s5_abort", 4'd5);
         tick();
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk_idle("s5_abort_wins", 4'd5);
      tick();
      chk_idle("s5_abort_wins2", 4'd5);
      $display("scenario 5: abort mid-burst, checks=%0d", checks);

      // 6: asynchronous reset mid-burst
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("s6_pwm_pre", {7'd0, pwm_out}, 8'd1);
      #3 rst_n = 1'b0;
      #1;
      chk_idle("s6_async", 4'd0);
      tick();
      tick();
      #3 rst_n = 1'b1;
      tick();
      chk_idle("s6_release", 4'd0);
      select_in = 4'd0;
      burst_len = 8'd3;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check_seq(3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, -1);
      tick();
      chk_idle("s6_after", 4'd0);
      $display("scenario 6: reset mid-burst then rerun, checks=%0d", checks);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/burst_carrier_gen.md
Name: burst_carrier_gen

Overview:
- Generates the ultrasonic carrier bursts that drive the phased-array delay line's pwm_in.
- Replaces the external Arduino PWM source.
- Registers and freezes the 4-bit beam-angle select seen by the delay/tap-select stage, so select changes only while the delay line is quiet.
- Enforces flush windows so no burst is ever split across two steering angles.

Parameters:
HALF_PERIOD, 625, clk cycles per carrier half-period (50 MHz / 40 kHz / 2).
FLUSH_CLKS, 8501, clk cycles needed to fully drain the downstream shift-register chain.

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request one burst sequence; sampled every clk
abort  in  1  synchronous abort of any activity
continuous  in  1  auto-repeat burst sequences while high
burst_len  in  8  carrier periods per burst; 0 = invalid
select_in  in  4  requested beam-angle code
select_out  out  4  frozen beam-angle code to the delay/tap-select stage
pwm_out  out  1  carrier output to the delay line input
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of each burst sequence

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: pwm_out=0, select_out=0, busy=0, done=0, state=IDLE, all counters 0. Reset asserted mid-burst clears everything immediately, with no done pulse.
- All outputs are registered. Counters are sized with $clog2 of their parameter.
- States: IDLE, FLUSH, BURST, TAIL.
- IDLE:
  - Trigger: start=1 and burst_len!=0 at edge T0.
  - At T0 the block latches burst_len and copies select_in into select_out.
  - From T0+1, busy=1.
  - If select_in differs from the previous select_out, go to FLUSH; otherwise go directly to BURST.
  - start with burst_len=0 is ignored: stay IDLE, busy stays 0, no done.
- FLUSH: pwm_out=0 for exactly FLUSH_CLKS cycles, then BURST.
- BURST:
  - pwm_out=1 for HALF_PERIOD cycles, then 0 for HALF_PERIOD cycles, repeated latched-burst_len times.
  - Duration is exactly 2*HALF_PERIOD*burst_len cycles.
  - First high cycle is the first BURST cycle: T0+1 when no flush, T0+1+FLUSH_CLKS when flushing.
- TAIL: pwm_out=0 for FLUSH_CLKS cycles, so the last edge exits the delay line.
- End of TAIL: on the next cycle done=1 for one cycle.
  - If continuous=1 at that edge, re-sample burst_len and select_in exactly as a new start. busy stays 1 and the next FLUSH or BURST begins in the same cycle done is high.
  - If burst_len=0 at that edge, go to IDLE.
  - Otherwise go to IDLE and busy=0 in the done cycle.
- start while busy=1 is ignored, not queued.
- select_in changes while busy are ignored until the next sample point.
- abort=1 (any state): next cycle state=IDLE, pwm_out=0, busy=0, no done. select_out keeps its value. abort wins over start in the same cycle.
- Counter wrap: half-period and period counters reset on each phase entry; there is no free-running carrier phase.

Test Plan:
1. Bench overrides HALF_PERIOD=4, FLUSH_CLKS=10. Reset, then start at T0 with burst_len=3 and select_in=0 (unchanged) -> pwm_out pattern 1111 0000 x3 from T0+1 (24 cycles); then 10 zero cycles; done=1 at T0+35; busy 1 over T0+1..T0+34, 0 at T0+35.
2. start with select_in=5 (select_out was 0) -> select_out=5 at T0+1; pwm_out=0 for 10 cycles; first high at T0+11; done at T0+45.
3. start with burst_len=0 -> busy, pwm_out and done stay 0 for 50 cycles.
4. continuous=1, burst_len=2, select constant -> done pulses every 16+10=26 cycles; pwm_out high again in each done cycle; busy never drops. Deassert continuous -> after the next done, busy=0.
5. abort during the 2nd carrier period, plus a start pulse while busy in the same run -> pwm_out=0 and busy=0 the next cycle; no done; the start while busy causes no extra burst.
6. rst_n low mid-BURST (asynchronous, between edges) -> pwm_out, busy and select_out go to 0 immediately, without waiting for clk. After release, a normal start reproduces scenario 1 timing.
